// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic ops, iterative shift-add multiply and optional
// restoring divider (enabled with `define ALU_MC_DIV_EN), valid/ready on both sides.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpNor  = 4'b1100;
  localparam logic [3:0] OpMul  = 4'b1000;
`ifdef ALU_MC_DIV_EN
  localparam logic [3:0] OpDivu = 4'b1001;
  localparam logic [3:0] OpRemu = 4'b1010;
`endif

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic [3:0]             op_q, op_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;
  logic [WIDTH-1:0]       res_q, res_d;
  logic                   ovf_q, ovf_d, err_q, err_d;

  logic                   cnt_last;
  logic [WIDTH-1:0]       add_res, sub_res;
  logic [WIDTH-1:0]       alu_res;
  logic                   alu_ovf, alu_err;
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_next;

  assign cnt_last = (cnt_q == CntW'(WIDTH - 1));
  assign add_res  = a_q + b_q;
  assign sub_res  = a_q - b_q;

  // Product register holds {partial high, unconsumed multiplier bits}; shift right each step.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? a_q : '0)};
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

`ifdef ALU_MC_DIV_EN
  // Same register reused as {remainder, dividend/quotient}; divide by zero yields
  // all-ones quotient and remainder = a without special casing.
  logic [WIDTH:0]         div_sh, div_sub;
  logic                   div_ge;
  logic [2*WIDTH-1:0]     div_next;

  assign div_sh   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, b_q});
  assign div_sub  = div_sh - {1'b0, b_q};
  assign div_next = {(div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                     prod_q[WIDTH-2:0], div_ge};
`endif

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (op_q)
      OpAnd: alu_res = a_q & b_q;
      OpOr:  alu_res = a_q | b_q;
      OpNor: alu_res = ~(a_q | b_q);
      OpSlt: alu_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      OpAdd: begin
        alu_res = add_res;
        alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpSub: begin
        alu_res = sub_res;
        alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          prod_d  = {{WIDTH{1'b0}}, b};
`ifdef ALU_MC_DIV_EN
          if (op == OpDivu || op == OpRemu) prod_d = {{WIDTH{1'b0}}, a};
`endif
          state_d = StExec;
        end
      end
      StExec: begin
        case (op_q)
          OpMul: begin
            prod_d = mul_next;
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_last) begin
              res_d   = mul_next[WIDTH-1:0];
              ovf_d   = |mul_next[2*WIDTH-1:WIDTH];
              err_d   = 1'b0;
              state_d = StDone;
            end
          end
`ifdef ALU_MC_DIV_EN
          OpDivu, OpRemu: begin
            prod_d = div_next;
            cnt_d  = cnt_q + CntW'(1);
            if (cnt_last) begin
              res_d   = (op_q == OpDivu) ? div_next[WIDTH-1:0] : div_next[2*WIDTH-1:WIDTH];
              ovf_d   = 1'b0;
              err_d   = (b_q == '0);
              state_d = StDone;
            end
          end
`endif
          default: begin
            res_d   = alu_res;
            ovf_d   = alu_ovf;
            err_d   = alu_err;
            state_d = StDone;
          end
        endcase
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign res       = res_q;
  assign zero      = (res_q == '0);
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: stimulus pushes expected results, a monitor pops and compares.
// Expectations for divide opcodes follow whether ALU_MC_DIV_EN is defined.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        zero, ovf, err;

  alu_mc #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zero      (zero),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitor: first cycle of out_valid is compared against the scoreboard, later cycles
  // of the same result must stay stable with in_ready low.
  exp_t cur;
  bit   seen = 0;
  bit   expect_idle = 0;

  always @(negedge clk) begin
    if (rst) begin
      seen        = 0;
      expect_idle = 0;
    end else begin
      if (expect_idle) begin
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        expect_idle = 0;
      end
      if (out_valid) begin
        if (!seen) begin
          if (sb.size() == 0) begin
            chk("unexpected_result", 64'd1, 64'd0);
          end else begin
            cur = sb.pop_front();
            chk("res", 64'(res), 64'(cur.res));
            chk("zero", 64'(zero), 64'(cur.res == 32'd0));
            chk("ovf", 64'(ovf), 64'(cur.ovf));
            chk("err", 64'(err), 64'(cur.err));
            chk("latency", 64'(cyc - cur.acc), 64'(cur.lat));
          end
          seen = 1;
        end else begin
          chk("hold_res", 64'(res), 64'(cur.res));
          chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        if (out_ready) begin
          seen        = 0;
          expect_idle = 1;
        end
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] r, input logic v, input logic e, input int lat,
                       input bit push);
    int   t;
    exp_t ex;
    t = 0;
    @(negedge clk); #1;
    while (!in_ready && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    if (!in_ready) chk("issue_timeout", 64'd0, 64'd1);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    if (push) begin
      ex.res = r; ex.ovf = v; ex.err = e; ex.lat = lat; ex.acc = cyc;
      sb.push_back(ex);
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'hDEAD_BEEF;
    op       = 4'b1111;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(in_ready && !out_valid && sb.size() == 0) && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 200) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  localparam logic [3:0] AND = 4'b0000, OR = 4'b0001, ADD = 4'b0010, SUB = 4'b0110;
  localparam logic [3:0] SLT = 4'b0111, NOR = 4'b1100, MUL = 4'b1000;
  localparam logic [3:0] DIVU = 4'b1001, REMU = 4'b1010;

  initial begin
    int t;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = '0;
    repeat (2) @(negedge clk);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    issue(ADD, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1, 0, 2, 1);
    issue(SUB, 32'd5,         32'd5,         32'd0,         0, 0, 2, 1);
    issue(SLT, 32'd3,         32'hFFFF_FFFF, 32'd1,         0, 0, 2, 1);
    issue(SLT, 32'hFFFF_FFFF, 32'd3,         32'd0,         0, 0, 2, 1);
    issue(SUB, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1, 0, 2, 1);
    issue(ADD, 32'hFFFF_FFFF, 32'd1,         32'd0,         0, 0, 2, 1);
    issue(AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 2, 1);
    issue(OR,  32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 0, 0, 2, 1);
    issue(NOR, 32'd0,         32'd0,         32'hFFFF_FFFF, 0, 0, 2, 1);
    issue(4'b0011, 32'd9,     32'd4,         32'd0,         0, 1, 2, 1);
    issue(MUL, 32'h0001_0000, 32'h0001_0000, 32'd0,         1, 0, 33, 1);
    issue(MUL, 32'd7,         32'd6,         32'd42,        0, 0, 33, 1);
    issue(MUL, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1, 0, 33, 1);
`ifdef ALU_MC_DIV_EN
    issue(DIVU, 32'd100, 32'd7, 32'd14,          0, 0, 33, 1);
    issue(REMU, 32'd100, 32'd7, 32'd2,           0, 0, 33, 1);
    issue(DIVU, 32'd5,   32'd0, 32'hFFFF_FFFF,   0, 1, 33, 1);
    issue(REMU, 32'd5,   32'd0, 32'd5,           0, 1, 33, 1);
`else
    issue(DIVU, 32'd100, 32'd7, 32'd0, 0, 1, 2, 1);
    issue(REMU, 32'd100, 32'd7, 32'd0, 0, 1, 2, 1);
`endif
    wait_idle();

    // Back-pressure: hold the result for 5 extra cycles.
    out_ready = 1'b0;
    issue(ADD, 32'd20, 32'd22, 32'd42, 0, 0, 2, 1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    if (!out_valid) chk("hold_timeout", 64'd0, 64'd1);
    repeat (5) @(negedge clk);
    #1 out_ready = 1'b1;
    wait_idle();

    // Reset in the middle of a multiply discards it.
    issue(MUL, 32'd123, 32'd456, 32'd0, 0, 0, 33, 0);
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("midrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk); #1 rst = 1'b0;
    #1 chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_res", 64'(res), 64'd0);
    repeat (35) @(negedge clk);
    chk("midrst_no_result", 64'(out_valid), 64'd0);
    issue(ADD, 32'd2, 32'd3, 32'd5, 0, 0, 2, 1);
    wait_idle();

    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 8..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port op  input  4  opcode.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port res  output  WIDTH  result.
REQ-012 SHALL have port zero  output  1  res equals 0.
REQ-013 SHALL have port ovf  output  1  signed overflow (ADD/SUB) or truncation (MUL).
REQ-014 SHALL have port err  output  1  illegal opcode or divide by zero.

Function
REQ-015 SHALL support opcodes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT, unsigned, res = 1 if a<b else 0; 1100 NOR; 1000 MUL, unsigned, low WIDTH bits; 1001 DIVU, quotient; 1010 REMU, remainder.
REQ-016 SHALL capture a, b, op on the cycle in_valid && in_ready; operands are ignored on all other cycles.
REQ-017 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-018 SHALL complete single-cycle ops (AND/OR/ADD/SUB/SLT/NOR, illegal) in EXEC for one cycle, so out_valid rises 2 cycles after acceptance.
REQ-019 SHALL implement MUL as iterative shift-add, one bit per cycle, staying WIDTH cycles in EXEC; out_valid rises WIDTH+1 cycles after acceptance.
REQ-020 SHALL implement DIVU/REMU as iterative restoring division, one bit per cycle, with the same WIDTH+1 latency as MUL.
REQ-021 SHALL hold res, zero, ovf, err and out_valid stable in DONE until out_valid && out_ready, then return to IDLE on that edge.
REQ-022 SHALL NOT accept a new request in the same cycle a result is consumed; the earliest next acceptance is the following cycle.
REQ-023 SHALL set ovf for ADD/SUB on two's-complement signed overflow, for MUL when the upper WIDTH product bits are nonzero, and to 0 for all other ops.
REQ-024 SHALL, on divide by zero, complete with the normal latency with DIVU res = all ones, REMU res = a, err = 1.
REQ-025 SHALL, on an undefined opcode, return res = 0, zero = 1, err = 1.
REQ-026 SHALL derive zero from the registered res in every cycle.
REQ-027 SHALL wrap ADD/SUB modulo 2^WIDTH.

Reset
REQ-028 SHALL, on rst high, asynchronously force state IDLE, in_ready = 1 after release, out_valid = 0, res = 0, zero = 1, ovf = 0, err = 0.
REQ-029 SHALL, on rst asserted mid-EXEC or in DONE, discard the operation with no result delivered.

Configuration
REQ-030 SHALL, with macro ALU_MC_DIV_EN defined, include the DIVU/REMU hardware per REQ-020/024.
REQ-031 SHALL, without ALU_MC_DIV_EN, contain no divider logic and treat 1001/1010 as illegal opcodes per REQ-025.

Verification
REQ-032 SHALL verify, with WIDTH=32: ADD a=0x7FFFFFFF b=1 -> res 0x80000000, ovf 1, out_valid at cycle +2.
REQ-033 SHALL verify: SUB a=5 b=5 -> res 0, zero 1, ovf 0; SLT a=3 b=0xFFFFFFFF -> res 1.
REQ-034 SHALL verify: MUL a=0x10000 b=0x10000 -> res 0, ovf 1, out_valid at cycle +33; MUL 7*6 -> 42, ovf 0.
REQ-035 SHALL verify, with ALU_MC_DIV_EN: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF, err 1. Without the macro: DIVU -> res 0, err 1.
REQ-036 SHALL verify: out_ready held 0 for 5 cycles -> res stable and in_ready 0 throughout; then out_ready 1 -> IDLE next cycle.
REQ-037 SHALL verify: rst pulsed at cycle 10 of a MUL -> out_valid 0, in_ready 1 after release, and the next ADD 2+3 -> 5.
